// File: rtl/result_writeback.sv
// Drains rows of four 32-bit sums from the output buffer and writes them,
// lane by lane, to strided row addresses in data memory.
module result_writeback #(
   parameter int AW   = 32,
   parameter int MAXR = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] row_stride,
   input  logic [4:0]    num_rows,
   input  logic          buf_empty,
   output logic          buf_rd_en,
   input  logic [127:0]  buf_data,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic          mem_ack,
   output logic          busy,
   output logic          done
);

   localparam int CW = $clog2(MAXR + 1);

   typedef enum logic [2:0] {IDLE, POP, CAPT, WR, DONE} state_t;

   state_t          state, state_nx;
   logic [AW-1:0]   row_addr;
   logic [AW-1:0]   row_stride_q;
   logic [4:0]      num_rows_q;
   logic [CW-1:0]   row_cnt;
   logic [CW-1:0]   row_cnt_nx;
   logic [1:0]      lane;
   logic [1:0]      lane_nx;
   logic [127:0]    row_reg;
   logic            wr_ack;

   assign row_cnt_nx = row_cnt + 1'b1;
   assign lane_nx    = lane + 2'd1;
   // ack only means something while a request is actually outstanding
   assign wr_ack     = (state == WR) && mem_req && mem_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start) state_nx = (num_rows == 5'd0) ? DONE : POP;
         POP:  if (!buf_empty) state_nx = CAPT;
         CAPT: state_nx = WR;
         WR:   if (wr_ack && lane == 2'd3)
                  state_nx = (5'(row_cnt_nx) == num_rows_q) ? DONE : POP;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign buf_rd_en = (state == POP) && !buf_empty;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_addr     <= '0;
         row_stride_q <= '0;
         num_rows_q   <= '0;
         row_cnt      <= '0;
         lane         <= '0;
         row_reg      <= '0;
         mem_req      <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               row_addr     <= base_addr;
               row_stride_q <= row_stride;
               num_rows_q   <= num_rows;
               row_cnt      <= '0;
               lane         <= '0;
            end
            CAPT: begin
               row_reg   <= buf_data;
               lane      <= '0;
               mem_req   <= 1'b1;
               mem_addr  <= row_addr;
               mem_wdata <= buf_data[31:0];
            end
            WR: if (wr_ack) begin
               if (lane != 2'd3) begin
                  // next lane's request is presented back-to-back
                  lane      <= lane_nx;
                  mem_addr  <= row_addr + {{(AW-4){1'b0}}, lane_nx, 2'b00};
                  mem_wdata <= row_reg[{lane_nx, 5'd0} +: 32];
               end else begin
                  mem_req  <= 1'b0;
                  row_cnt  <= row_cnt_nx;
                  row_addr <= row_addr + row_stride_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_result_writeback.sv
// Randomized bench for result_writeback: buffer/memory responders plus a
// queue-based model of the expected write stream and job latency.
module tb_result_writeback;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [31:0]  base_addr = '0;
   logic [31:0]  row_stride = '0;
   logic [4:0]   num_rows = '0;
   logic         buf_empty = 1'b1;
   logic         buf_rd_en;
   logic [127:0] buf_data = '0;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic         mem_ack = 1'b0;
   logic         busy;
   logic         done;

   result_writeback #(.AW(32), .MAXR(16)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .row_stride(row_stride), .num_rows(num_rows), .buf_empty(buf_empty),
      .buf_rd_en(buf_rd_en), .buf_data(buf_data), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [31:0]  exp_a[$];
   logic [31:0]  exp_d[$];
   logic [127:0] bq[$];
   int ack_delay = 0;
   int wcnt = 0;
   bit stray = 0;
   int hold_until = -1;
   int writes = 0, pops = 0, done_cnt = 0, first_pop_cyc = -1;
   bit prev_wait = 0;
   logic [31:0] prev_a = '0, prev_d = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Responders: drive inputs at negedge+1, sample outputs at negedge+2.
   always begin
      @(negedge clk);
      #1;
      if (!mem_req) begin
         mem_ack = stray ? 1'($urandom % 2) : 1'b0;
         wcnt = 0;
      end else if (wcnt >= ack_delay) begin
         mem_ack = 1'b1;
         wcnt = 0;
      end else begin
         mem_ack = 1'b0;
         wcnt++;
      end
      buf_empty = (bq.size() == 0) || (cyc <= hold_until);
      #1;
      if (!rst) begin
         if (buf_rd_en) begin
            pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            if (bq.size() == 0) chk("pop_from_empty", 1, 0);
            else buf_data = bq.pop_front();
         end
         if (mem_req && prev_wait) begin
            chk("addr_stable", mem_addr, prev_a);
            chk("data_stable", mem_wdata, prev_d);
         end
         if (mem_req && mem_ack) begin
            writes++;
            if (exp_a.size() == 0) chk("extra_write", 1, 0);
            else begin
               chk("wr_addr", mem_addr, exp_a.pop_front());
               chk("wr_data", mem_wdata, exp_d.pop_front());
            end
         end
         prev_wait = mem_req && !mem_ack;
         prev_a = mem_addr;
         prev_d = mem_wdata;
         if (done) done_cnt++;
      end else prev_wait = 0;
   end

   int s_cyc;

   task automatic launch(input logic [31:0] base, input logic [31:0] stride, input int n,
                         input int d, input int h, input bit fixed,
                         input logic [127:0] r0, input logic [127:0] r1);
      logic [127:0] row;
      logic [31:0]  a;
      bq.delete(); exp_a.delete(); exp_d.delete();
      for (int r = 0; r < n; r++) begin
         if (fixed) row = (r == 0) ? r0 : r1;
         else row = {$urandom, $urandom, $urandom, $urandom};
         bq.push_back(row);
         for (int k = 0; k < 4; k++) begin
            a = base + 32'(r) * stride + 32'(4 * k);
            exp_a.push_back(a);
            exp_d.push_back(row[32*k +: 32]);
         end
      end
      ack_delay = d;
      writes = 0; pops = 0; done_cnt = 0; first_pop_cyc = -1;
      @(negedge clk);
      start = 1'b1; base_addr = base; row_stride = stride; num_rows = 5'(n);
      s_cyc = cyc;
      hold_until = s_cyc + h;
   endtask

   task automatic run_job(input logic [31:0] base, input logic [31:0] stride, input int n,
                          input int d, input int h, input bit noise, input bit fixed,
                          input logic [127:0] r0, input logic [127:0] r1);
      int lat, exp_lat;
      launch(base, stride, n, d, h, fixed, r0, r1);
      exp_lat = (n == 0) ? 1 : 1 + h + n * (2 + 4 * (d + 1));
      lat = -1;
      for (int i = 0; i < 4000; i++) begin
         #3;
         if (done) begin lat = cyc - s_cyc; break; end
         @(negedge clk);
         start = noise && ($urandom % 3 == 0);
         base_addr = $urandom; row_stride = $urandom; num_rows = 5'($urandom_range(0, 16));
      end
      chk("done_latency", lat, exp_lat);
      @(negedge clk);
      start = 1'b0;
      #3;
      chk("idle_after_done", busy, 0);
      chk("write_count", writes, 4 * n);
      chk("pop_count", pops, n);
      chk("writes_left", exp_a.size(), 0);
      chk("done_pulses", done_cnt, 1);
      if (n > 0) chk("first_pop_cycle", first_pop_cyc - s_cyc, 1 + h);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      bit found;
      repeat (3) @(negedge clk);
      #3;
      chk("rst_buf_rd_en", buf_rd_en, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      @(negedge clk);
      rst = 1'b0;

      // two fixed rows, zero-wait ack
      run_job(32'h1000, 32'h40, 2, 0, 0, 0, 1,
              128'h00000004_00000003_00000002_00000001,
              128'hFFFFFFFF_FFFFFFFE_FFFFFFFC_FFFFFFF8);
      // empty job
      run_job(32'h2000, 32'h10, 0, 0, 0, 0, 0, '0, '0);
      // buffer empty for 5 cycles after start
      run_job(32'h3000, 32'h20, 1, 0, 5, 0, 0, '0, '0);
      // slow ack, with stray acks while idle
      stray = 1;
      run_job(32'h4000, 32'h100, 2, 3, 0, 0, 0, '0, '0);

      // abort mid-row at lane 2
      launch(32'h5000, 32'h80, 2, 3, 0, 0, '0, '0);
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 200; i++) begin
         #3;
         if (mem_req && mem_addr == 32'h5008) begin found = 1; break; end
         @(negedge clk);
      end
      chk("reached_lane2", found, 1);
      rst = 1'b1;
      #1;
      chk("abort_mem_req", mem_req, 0);
      chk("abort_busy", busy, 0);
      chk("abort_rd_en", buf_rd_en, 0);
      done_cnt = 0; writes = 0; pops = 0;
      repeat (3) @(negedge clk);
      #3;
      chk("abort_no_done", done_cnt, 0);
      chk("abort_mem_addr", mem_addr, 0);
      rst = 1'b0;
      bq.delete(); exp_a.delete(); exp_d.delete();
      run_job(32'h6000, 32'h40, 2, 0, 0, 0, 0, '0, '0);

      // address wrap-around
      run_job(32'hFFFF_FFF8, 32'h8, 2, 0, 0, 0, 0, '0, '0);

      // random jobs with start noise while busy
      for (int j = 0; j < 6; j++) begin
         n = $urandom_range(0, 16);
         run_job({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, {$urandom, 2'b00} >> 2 << 2 , n,
                 $urandom_range(0, 2), $urandom_range(0, 3), 1, 0, '0, '0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
